// File: rtl/pool2d_window_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : pool2d_window_buffer_if
// Purpose  : Pixel-in / window-out handshake bundle for pool2d_window_buffer.
// Revision : 1.0  initial release
// ============================================================================
interface pool2d_window_buffer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int WIN        = 4
);
    logic [DATA_WIDTH-1:0] data_in_0 [0:0];
    logic                  data_in_0_valid;
    logic                  data_in_0_ready;
    logic [DATA_WIDTH-1:0] data_out_0 [WIN-1:0];
    logic                  data_out_0_valid;
    logic                  data_out_0_ready;

    // Block side of the bundle.
    modport slave (
        input  data_in_0,
        input  data_in_0_valid,
        output data_in_0_ready,
        output data_out_0,
        output data_out_0_valid,
        input  data_out_0_ready
    );

    // Pixel producer / window consumer side.
    modport master (
        output data_in_0,
        output data_in_0_valid,
        input  data_in_0_ready,
        input  data_out_0,
        input  data_out_0_valid,
        output data_out_0_ready
    );
endinterface
`default_nettype wire

// File: rtl/pool2d_window_buffer.sv
`default_nettype none
// ============================================================================
// Module   : pool2d_window_buffer
// Purpose  : Raster-order pixel stream to stride-aligned KxK window beats.
// Revision : 1.0  initial release
// ============================================================================
module pool2d_window_buffer #(
    parameter int DATA_IN_0_PRECISION_0 = 8,
    parameter int DATA_IN_0_PRECISION_1 = 3,
    parameter int IMG_WIDTH             = 8,
    parameter int IMG_HEIGHT            = 8,
    parameter int KERNEL_WIDTH          = 2,
    parameter int KERNEL_HEIGHT         = 2,
    parameter int STRIDE                = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    pool2d_window_buffer_if.slave bus
);
    localparam int c_win    = KERNEL_HEIGHT * KERNEL_WIDTH;
    localparam int c_col_w  = (IMG_WIDTH > 1)     ? $clog2(IMG_WIDTH)     : 1;
    localparam int c_row_w  = (IMG_HEIGHT > 1)    ? $clog2(IMG_HEIGHT)    : 1;
    localparam int c_slot_w = (KERNEL_HEIGHT > 1) ? $clog2(KERNEL_HEIGHT) : 1;
    localparam int c_ph_w   = (STRIDE > 1)        ? $clog2(STRIDE)        : 1;

    localparam logic [c_col_w-1:0]  c_col_last  = c_col_w'(IMG_WIDTH - 1);
    localparam logic [c_col_w-1:0]  c_col_first = c_col_w'(KERNEL_WIDTH - 1);
    localparam logic [c_row_w-1:0]  c_row_last  = c_row_w'(IMG_HEIGHT - 1);
    localparam logic [c_row_w-1:0]  c_row_first = c_row_w'(KERNEL_HEIGHT - 1);
    localparam logic [c_slot_w-1:0] c_slot_last = c_slot_w'(KERNEL_HEIGHT - 1);
    localparam logic [c_slot_w:0]   c_kh        = (c_slot_w + 1)'(KERNEL_HEIGHT);
    localparam logic [c_ph_w-1:0]   c_ph_last   = c_ph_w'(STRIDE - 1);

    generate
        if (STRIDE < 1 || KERNEL_WIDTH > IMG_WIDTH || KERNEL_HEIGHT > IMG_HEIGHT ||
            DATA_IN_0_PRECISION_1 < 0) begin : g_bad_params
            $error("pool2d_window_buffer: illegal parameter set");
        end
    endgenerate

    logic [c_col_w-1:0]  r_col;
    logic [c_row_w-1:0]  r_row;
    logic [c_slot_w-1:0] r_slot;
    logic [c_ph_w-1:0]   r_col_ph;
    logic [c_ph_w-1:0]   r_row_ph;
    logic [DATA_IN_0_PRECISION_0-1:0] r_line [0:KERNEL_HEIGHT-1][0:IMG_WIDTH-1];
    logic [DATA_IN_0_PRECISION_0-1:0] r_out_data [c_win-1:0];
    logic                             r_out_valid;

    logic                             w_in_ready;
    logic                             w_accept;
    logic                             w_complete;
    logic [c_ph_w-1:0]                w_col_ph_next;
    logic [c_ph_w-1:0]                w_row_ph_next;
    logic [c_slot_w:0]                w_slot_sum [KERNEL_HEIGHT];
    logic [c_slot_w-1:0]              w_slot_idx [KERNEL_HEIGHT];
    logic [c_col_w-1:0]               w_col_idx  [KERNEL_WIDTH];
    logic [DATA_IN_0_PRECISION_0-1:0] w_win      [c_win-1:0];

    assign w_in_ready = !r_out_valid || bus.data_out_0_ready;
    assign w_accept   = bus.data_in_0_valid && w_in_ready;

    // Stride phases are zero exactly on the rows/columns where a window ends.
    assign w_complete = w_accept && (r_row >= c_row_first) && (r_col >= c_col_first) &&
                        (r_row_ph == '0) && (r_col_ph == '0);

    assign w_col_ph_next = (r_col_ph == c_ph_last) ? '0 : r_col_ph + c_ph_w'(1);
    assign w_row_ph_next = (r_row_ph == c_ph_last) ? '0 : r_row_ph + c_ph_w'(1);

    assign bus.data_in_0_ready  = w_in_ready;
    assign bus.data_out_0       = r_out_data;
    assign bus.data_out_0_valid = r_out_valid;

    // Window row m is the slot one past the current slot plus m, modulo KERNEL_HEIGHT.
    always_comb begin
        for (int m = 0; m < KERNEL_HEIGHT; m++) begin
            w_slot_sum[m] = {1'b0, r_slot} + (c_slot_w + 1)'(m + 1);
            w_slot_idx[m] = (w_slot_sum[m] >= c_kh) ? c_slot_w'(w_slot_sum[m] - c_kh)
                                                    : c_slot_w'(w_slot_sum[m]);
        end
        for (int n = 0; n < KERNEL_WIDTH; n++) begin
            w_col_idx[n] = r_col - c_col_w'(KERNEL_WIDTH - 1 - n);
        end
    end

    always_comb begin
        for (int m = 0; m < KERNEL_HEIGHT; m++) begin
            for (int n = 0; n < KERNEL_WIDTH; n++) begin
                if (m == KERNEL_HEIGHT - 1 && n == KERNEL_WIDTH - 1) begin
                    w_win[m*KERNEL_WIDTH + n] = bus.data_in_0[0];
                end else begin
                    w_win[m*KERNEL_WIDTH + n] = r_line[w_slot_idx[m]][w_col_idx[n]];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_col    <= '0;
            r_row    <= '0;
            r_slot   <= '0;
            r_col_ph <= '0;
            r_row_ph <= '0;
        end else if (w_accept) begin
            if (r_col == c_col_last) begin
                r_col    <= '0;
                r_col_ph <= '0;
                if (r_row == c_row_last) begin
                    r_row    <= '0;
                    r_slot   <= '0;
                    r_row_ph <= '0;
                end else begin
                    r_row  <= r_row + c_row_w'(1);
                    r_slot <= (r_slot == c_slot_last) ? '0 : r_slot + c_slot_w'(1);
                    if (r_row >= c_row_first) begin
                        r_row_ph <= w_row_ph_next;
                    end
                end
            end else begin
                r_col <= r_col + c_col_w'(1);
                if (r_col >= c_col_first) begin
                    r_col_ph <= w_col_ph_next;
                end
            end
        end
    end

    // Line buffer content is don't-care after reset, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_line[r_slot][r_col] <= bus.data_in_0[0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            for (int i = 0; i < c_win; i++) begin
                r_out_data[i] <= '0;
            end
        end else if (w_complete) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_win;
        end else if (bus.data_out_0_ready) begin
            r_out_valid <= 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_pool2d_window_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pool2d_window_buffer
// Purpose  : Directed table-driven bench for pool2d_window_buffer.
// Revision : 1.0  initial release
// ============================================================================
module tb_pool2d_window_buffer;
    logic clk;
    logic rst;

    int n_vec  = 0;
    int n_miss = 0;

    pool2d_window_buffer_if #(.DATA_WIDTH(8), .WIN(4)) if0 ();
    pool2d_window_buffer_if #(.DATA_WIDTH(8), .WIN(9)) if1 ();
    pool2d_window_buffer_if #(.DATA_WIDTH(8), .WIN(4)) if2 ();

    pool2d_window_buffer #(
        .DATA_IN_0_PRECISION_0(8), .DATA_IN_0_PRECISION_1(3),
        .IMG_WIDTH(4), .IMG_HEIGHT(4), .KERNEL_WIDTH(2), .KERNEL_HEIGHT(2), .STRIDE(2)
    ) u0 (.clk(clk), .rst(rst), .bus(if0.slave));

    pool2d_window_buffer #(
        .DATA_IN_0_PRECISION_0(8), .DATA_IN_0_PRECISION_1(3),
        .IMG_WIDTH(4), .IMG_HEIGHT(4), .KERNEL_WIDTH(3), .KERNEL_HEIGHT(3), .STRIDE(1)
    ) u1 (.clk(clk), .rst(rst), .bus(if1.slave));

    pool2d_window_buffer #(
        .DATA_IN_0_PRECISION_0(8), .DATA_IN_0_PRECISION_1(3),
        .IMG_WIDTH(5), .IMG_HEIGHT(5), .KERNEL_WIDTH(2), .KERNEL_HEIGHT(2), .STRIDE(2)
    ) u2 (.clk(clk), .rst(rst), .bus(if2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  pix;
        logic        vin;
        logic        rdy;
        logic        exp_ir;
        logic        exp_ov;
        logic [31:0] exp_win;
    } vec_t;

    vec_t tv[$];

    logic [71:0] w0, w1, w2;
    logic [71:0] q0[$], q1[$], q2[$];

    // Element i of the window occupies bits [8*i +: 8].
    always_comb begin
        w0 = '0;
        w1 = '0;
        w2 = '0;
        for (int i = 0; i < 4; i++) w0[8*i +: 8] = if0.data_out_0[i];
        for (int i = 0; i < 9; i++) w1[8*i +: 8] = if1.data_out_0[i];
        for (int i = 0; i < 4; i++) w2[8*i +: 8] = if2.data_out_0[i];
    end

    // Transfer monitors, sampled mid-low-phase where inputs are settled.
    always begin
        @(negedge clk);
        #3;
        if (rst) begin
            if (if0.data_out_0_valid && if0.data_out_0_ready) q0.push_back(w0);
            if (if1.data_out_0_valid && if1.data_out_0_ready) q1.push_back(w1);
            if (if2.data_out_0_valid && if2.data_out_0_ready) q2.push_back(w2);
        end
    end

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [7:0] pix, input logic vin, input logic rdy,
                       input logic ir, input logic ov, input logic [31:0] win);
        tv.push_back('{pix, vin, rdy, ir, ov, win});
    endtask

    function automatic logic [31:0] s2_win(input int p);
        case (p)
            5:       return 32'h05040100;
            7:       return 32'h07060302;
            13:      return 32'h0D0C0908;
            15:      return 32'h0F0E0B0A;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic s2_done(input int p);
        return (p == 5 || p == 7 || p == 13 || p == 15);
    endfunction

    function automatic logic [71:0] wmodel(input int w, input int kh, input int kw,
                                           input int r0, input int c0, input int off);
        logic [71:0] res;
        res = '0;
        for (int m = 0; m < kh; m++)
            for (int n = 0; n < kw; n++)
                res[8*(m*kw+n) +: 8] = 8'(off + (r0 + m) * w + c0 + n);
        return res;
    endfunction

    function automatic logic [71:0] qget(input int which, input int k);
        case (which)
            0:       return (k < q0.size()) ? q0[k] : {72{1'bx}};
            1:       return (k < q1.size()) ? q1[k] : {72{1'bx}};
            default: return (k < q2.size()) ? q2[k] : {72{1'bx}};
        endcase
    endfunction

    task automatic idle_all();
        if0.data_in_0_valid = 1'b0; if0.data_in_0[0] = 8'h00; if0.data_out_0_ready = 1'b1;
        if1.data_in_0_valid = 1'b0; if1.data_in_0[0] = 8'h00; if1.data_out_0_ready = 1'b1;
        if2.data_in_0_valid = 1'b0; if2.data_in_0[0] = 8'h00; if2.data_out_0_ready = 1'b1;
    endtask

    task automatic drive0(input logic [7:0] pix, input logic vin, input logic rdy);
        @(negedge clk);
        if0.data_in_0[0]     = pix;
        if0.data_in_0_valid  = vin;
        if0.data_out_0_ready = rdy;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int budget;
        logic acc;

        rst = 1'b0;
        idle_all();
        if0.data_out_0_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", if0.data_out_0_valid, 1'b0);
        chk("reset_data",  w0, 72'h0);
        chk("reset_ready", if0.data_in_0_ready, 1'b1);
        chk("reset_valid_k3", if1.data_out_0_valid, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Frame 1: gap-free, ready held high.
        for (int p = 0; p < 16; p++) add(8'(p), 1'b1, 1'b1, 1'b1, s2_done(p), s2_win(p));
        // Frame 2: 5-cycle stall on the first window, then input bubbles.
        for (int p = 0; p < 6; p++) add(8'(p), 1'b1, 1'b1, 1'b1, s2_done(p), s2_win(p));
        for (int k = 0; k < 5; k++) add(8'd6, 1'b1, 1'b0, 1'b0, 1'b1, 32'h05040100);
        for (int p = 6; p < 10; p++) add(8'(p), 1'b1, 1'b1, 1'b1, s2_done(p), s2_win(p));
        add(8'hEE, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        add(8'hEE, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        for (int p = 10; p < 16; p++) add(8'(p), 1'b1, 1'b1, 1'b1, s2_done(p), s2_win(p));
        add(8'hEE, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);

        foreach (tv[i]) begin
            drive0(tv[i].pix, tv[i].vin, tv[i].rdy);
            #1;
            chk($sformatf("vec%0d_in_ready", i), if0.data_in_0_ready, tv[i].exp_ir);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_out_valid", i), if0.data_out_0_valid, tv[i].exp_ov);
            if (tv[i].exp_ov) chk($sformatf("vec%0d_window", i), w0, {40'h0, tv[i].exp_win});
        end

        // Two frames with random input bubbles and random downstream ready.
        q0.delete();
        idx = 0;
        budget = 0;
        while (idx < 32 && budget < 2000) begin
            @(negedge clk);
            if0.data_in_0_valid  = ($urandom_range(0, 3) != 0);
            if0.data_in_0[0]     = if0.data_in_0_valid ? 8'(idx) : 8'hEE;
            if0.data_out_0_ready = ($urandom_range(0, 2) != 0);
            #1;
            acc = if0.data_in_0_valid && if0.data_in_0_ready;
            @(posedge clk);
            if (acc) idx++;
            budget++;
        end
        if (idx < 32) chk("rnd_timeout", 72'(idx), 72'd32);
        @(negedge clk);
        if0.data_in_0_valid  = 1'b0;
        if0.data_out_0_ready = 1'b1;
        repeat (4) @(posedge clk);
        chk("rnd_count", 72'(q0.size()), 72'd8);
        for (int k = 0; k < 8; k++)
            chk($sformatf("rnd_win%0d", k), qget(0, k),
                wmodel(4, 2, 2, ((k % 4) / 2) * 2, (k % 2) * 2, 16 * (k / 4)));

        // 3x3/S1 on 4x4 and 2x2/S2 on 5x5, streamed gap-free in parallel.
        q1.delete();
        q2.delete();
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if1.data_in_0_valid = (i < 16);
            if1.data_in_0[0]    = 8'(i);
            if2.data_in_0_valid = 1'b1;
            if2.data_in_0[0]    = 8'(i);
        end
        @(negedge clk);
        if1.data_in_0_valid = 1'b0;
        if2.data_in_0_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("k3_count", 72'(q1.size()), 72'd4);
        chk("k3_first", qget(1, 0), 72'h0A_09_08_06_05_04_02_01_00);
        chk("k3_win1",  qget(1, 1), wmodel(4, 3, 3, 0, 1, 0));
        chk("k3_win2",  qget(1, 2), wmodel(4, 3, 3, 1, 0, 0));
        chk("k3_last",  qget(1, 3), 72'h0F_0E_0D_0B_0A_09_07_06_05);
        chk("w5_count", 72'(q2.size()), 72'd4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("w5_win%0d", k), qget(2, k), wmodel(5, 2, 2, (k / 2) * 2, (k % 2) * 2, 0));
        chk("w5_idle_valid", if2.data_out_0_valid, 1'b0);

        // Mid-frame reset with a stalled window pending.
        for (int p = 0; p < 7; p++) drive0(8'(p), 1'b1, 1'b1);
        drive0(8'd7, 1'b1, 1'b0);
        drive0(8'hEE, 1'b0, 1'b0);
        #1;
        chk("pending_valid", if0.data_out_0_valid, 1'b1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_valid", if0.data_out_0_valid, 1'b0);
        chk("midrst_data",  w0, 72'h0);
        chk("midrst_ready", if0.data_in_0_ready, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        q0.delete();
        for (int p = 0; p < 16; p++) drive0(8'(100 + p), 1'b1, 1'b1);
        drive0(8'hEE, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        chk("midrst_count", 72'(q0.size()), 72'd4);
        chk("midrst_first", qget(0, 0), 72'h69686564);
        chk("midrst_last",  qget(0, 3), wmodel(4, 2, 2, 2, 2, 100));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
`default_nettype wire
